fu_result_queue: RTL and testbench

Per-functional-unit result buffer between an execution unit (ALU, multiplier, or memory unit) and the round-robin CDB arbiter. Each unit's results go into a small FIFO of `cdb_t` entries. The arbiter grants each unit's slot once every three cycles, so the head entry is held until that slot's `ack`. The execution unit is back-pressured when the queue is full. On a branch mispredict flush, all buffered results are discarded.

---
 rtl/fu_result_queue_pkg.sv | 18 +
 rtl/rv32i_types.sv | 11 +
 rtl/fu_result_queue_if.sv | 25 ++
 rtl/fu_result_queue.sv | 86 ++++++++
 tb/tb_fu_result_queue.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/fu_result_queue_pkg.sv
// Local definitions for the per-unit CDB result queue: default depth and the
// push/pop operation encoding used to update the pointers and the occupancy.
package fu_result_queue_pkg;

  localparam int unsigned FRQ_DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } queue_op_e;

  function automatic queue_op_e queue_op(input logic push, input logic pop);
    return queue_op_e'({push, pop});
  endfunction

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I core types. The common data bus carries one completed result
// per cycle from a functional unit back to the ROB and reservation stations.
package rv32i_types;

  typedef struct packed {
    logic        valid;
    logic [3:0]  rob_idx;
    logic [31:0] data;
  } cdb_t;

endpackage

// File: rtl/fu_result_queue_if.sv
// Handshake bundle between one execution unit, its result queue and the CDB
// arbiter. The master side is the producer/arbiter pair; the slave is the queue.
interface fu_result_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic               flush;
  rv32i_types::cdb_t  in_cdb;
  logic               in_ready;
  rv32i_types::cdb_t  out_cdb;
  logic               ack;
  logic [CNT_W-1:0]   count;

  modport master (
    output flush, in_cdb, ack,
    input  in_ready, out_cdb, count
  );

  modport slave (
    input  flush, in_cdb, ack,
    output in_ready, out_cdb, count
  );

endinterface

// File: rtl/fu_result_queue.sv
// Circular result buffer holding a unit's completed results until its CDB
// arbiter slot acks the head. Flush discards everything in one cycle.
module fu_result_queue
  import rv32i_types::*;
  import fu_result_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FRQ_DEFAULT_DEPTH
) (
  input logic              clk,
  input logic              rst,
  fu_result_queue_if.slave q
);

  localparam int unsigned      PTR_W = $clog2(DEPTH);
  localparam int unsigned      CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  cdb_t             mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      push;
  logic      pop;
  queue_op_e op;

  // in_ready comes from registered occupancy only, so a pop in a full cycle
  // frees a slot but cannot admit that same cycle's push.
  assign q.in_ready = (count_q != FULL);
  assign push       = q.in_cdb.valid && q.in_ready && !q.flush;
  assign pop        = q.ack && (count_q != '0) && !q.flush;
  assign op         = queue_op(push, pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          tail_d  = tail_q + PTR_W'(1);
          count_d = count_q + CNT_W'(1);
        end
        OP_POP: begin
          head_d  = head_q + PTR_W'(1);
          count_d = count_q - CNT_W'(1);
        end
        OP_BOTH: begin
          head_d = head_q + PTR_W'(1);
          tail_d = tail_q + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage has no reset; count gates every read, so stale
  // contents are never visible and the array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= q.in_cdb;
    end
  end

  assign q.out_cdb = (count_q != '0) ? mem_q[head_q] : '0;
  assign q.count   = count_q;

endmodule

// File: tb/tb_fu_result_queue.sv
// Directed bench for fu_result_queue: a vector table for single-cycle behaviour
// plus scoreboarded push/ack streams for fill, steady state and pointer wrap.
module tb_fu_result_queue;
  import rv32i_types::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fu_result_queue_if #(.DEPTH(DEPTH)) bus ();

  fu_result_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic cdb_t make_cdb(input int n);
    cdb_t c;
    c.valid   = 1'b1;
    c.rob_idx = 4'(n);
    c.data    = 32'hC0DE_0000 | 32'(n);
    return c;
  endfunction

  typedef struct {
    logic       rst;
    logic       flush;
    logic       valid;
    logic       ack;
    int         tag;
    logic [2:0] exp_count;
    logic       exp_ready;
    int         exp_tag;    // 0 means the queue must present '0
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic v, input logic a,
                              input int tag, input logic [2:0] ec, input logic er, input int et);
    vec_t x;
    x.rst = r; x.flush = f; x.valid = v; x.ack = a; x.tag = tag;
    x.exp_count = ec; x.exp_ready = er; x.exp_tag = et;
    return x;
  endfunction

  vec_t vecs[26];

  // Model-checked stream: push every cycle until n_results are accepted, ack
  // once per ack_period cycles; outputs are compared to a queue model each cycle.
  task automatic run_stream(input int n_results, input int ack_period, input int tag_base);
    cdb_t m_q[$];
    int   pushed = 0;
    int   popped = 0;
    int   cyc    = 0;
    logic push_ok;
    logic pop_ok;
    cdb_t exp_out;
    while (popped < n_results && cyc < 300) begin
      bus.flush  = 1'b0;
      bus.ack    = ((cyc % ack_period) == ack_period - 1);
      bus.in_cdb = (pushed < n_results) ? make_cdb(tag_base + pushed) : '0;
      exp_out = (m_q.size() != 0) ? m_q[0] : '0;
      check($sformatf("s%0d c%0d count", tag_base, cyc), 64'(bus.count), 64'(m_q.size()));
      check($sformatf("s%0d c%0d in_ready", tag_base, cyc), 64'(bus.in_ready),
            64'(m_q.size() != DEPTH));
      check($sformatf("s%0d c%0d out_cdb", tag_base, cyc), 64'(bus.out_cdb), 64'(exp_out));
      check($sformatf("s%0d c%0d count<=DEPTH", tag_base, cyc), 64'(bus.count <= 3'(DEPTH)), 64'(1));
      push_ok = bus.in_cdb.valid && (m_q.size() != DEPTH);
      pop_ok  = bus.ack && (m_q.size() != 0);
      if (pop_ok) begin
        check($sformatf("s%0d pop%0d order", tag_base, popped), 64'(bus.out_cdb),
              64'(make_cdb(tag_base + popped)));
      end
      @(posedge clk);
      #1;
      if (pop_ok) begin
        void'(m_q.pop_front());
        popped++;
      end
      if (push_ok) begin
        m_q.push_back(make_cdb(tag_base + pushed));
        pushed++;
      end
      cyc++;
    end
    check($sformatf("s%0d results drained", tag_base), 64'(popped), 64'(n_results));
  endtask

  initial begin
    //           rst   flush valid ack   tag  cnt rdy exp_tag
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 1, 0);  // ack on empty
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 1, 0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 1, 0);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 1, 0);
    vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  1, 1, 1, 1);  // A visible next cycle
    vecs[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  2, 2, 1, 1);
    vecs[6]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  3, 3, 1, 1);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1,  0, 2, 1, 2);  // pop A
    vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  4, 3, 1, 2);
    vecs[9]  = mk(1'b0, 1'b0, 1'b1, 1'b0,  5, 4, 0, 2);  // full
    vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b1,  6, 3, 1, 3);  // full: pop B, refuse 6
    vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0,  6, 4, 0, 3);  // re-push 6
    vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1,  0, 3, 1, 4);
    vecs[13] = mk(1'b0, 1'b1, 1'b1, 1'b1,  7, 0, 1, 0);  // flush beats push+pop
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 1, 0);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 1'b0,  8, 1, 1, 8);  // 7 never appears
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 1, 0);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 1, 0);
    vecs[18] = mk(1'b0, 1'b0, 1'b1, 1'b1,  9, 1, 1, 9);  // ack on empty + push
    vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b1, 10, 1, 1, 10); // push+pop at count 1
    vecs[20] = mk(1'b0, 1'b1, 1'b0, 1'b0,  0, 0, 1, 0);
    vecs[21] = mk(1'b0, 1'b0, 1'b1, 1'b0, 11, 1, 1, 11);
    vecs[22] = mk(1'b1, 1'b0, 1'b1, 1'b1, 12, 0, 1, 0);  // reset beats push+pop
    vecs[23] = mk(1'b0, 1'b0, 1'b0, 1'b0,  0, 0, 1, 0);
    vecs[24] = mk(1'b0, 1'b0, 1'b1, 1'b0, 13, 1, 1, 13);
    vecs[25] = mk(1'b0, 1'b0, 1'b0, 1'b1,  0, 0, 1, 0);

    rst        = 1'b1;
    bus.flush  = 1'b0;
    bus.ack    = 1'b0;
    bus.in_cdb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset count", 64'(bus.count), 64'(0));
    check("reset in_ready", 64'(bus.in_ready), 64'(1));
    check("reset out_cdb", 64'(bus.out_cdb), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      rst        = vecs[i].rst;
      bus.flush  = vecs[i].flush;
      bus.ack    = vecs[i].ack;
      bus.in_cdb = vecs[i].valid ? make_cdb(vecs[i].tag) : '0;
      @(posedge clk);
      #1;
      check($sformatf("v%0d count", i), 64'(bus.count), 64'(vecs[i].exp_count));
      check($sformatf("v%0d in_ready", i), 64'(bus.in_ready), 64'(vecs[i].exp_ready));
      check($sformatf("v%0d out_cdb", i), 64'(bus.out_cdb),
            (vecs[i].exp_tag == 0) ? 64'(0) : 64'(make_cdb(vecs[i].exp_tag)));
    end
    rst        = 1'b0;
    bus.flush  = 1'b0;
    bus.ack    = 1'b0;
    bus.in_cdb = '0;

    run_stream(20, 3, 32);   // fill, then one accepted push per pop
    run_stream(10, 1, 64);   // push+pop every cycle across pointer wrap

    bus.in_cdb = '0;
    bus.ack    = 1'b0;
    @(posedge clk);
    #1;
    check("final count", 64'(bus.count), 64'(0));
    check("final out_cdb", 64'(bus.out_cdb), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
